spi_mem_arbiter: RTL and testbench

//  Upstream stage of the SPI memory controller: two-master arbiter and region decoder.

---
 rtl/spi_hub_pkg.sv | 21 ++
 rtl/rr_arbiter_2.sv | 37 +++
 rtl/spi_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_hub_pkg.sv
// spi_hub_pkg: shared types and constants for the SPI memory hub front end.
//   arb_state_t        - arbiter/issue FSM states
//   master_id_t        - requester identity (M0 = CPU, M1 = boot/UART loader)
//   FLASH_BASE_DEFAULT - default first address of the Flash window
package spi_hub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  localparam logic [15:0] FLASH_BASE_DEFAULT = 16'hC000;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter.
//   clk, reset_n - clock, synchronous active-low reset
//   req[1:0]     - request lines (bit 0 = M0, bit 1 = M1)
//   advance      - commit the current grant as the last grant
//   grant        - combinational grant for the current request pattern
// The last grant resets to M1 so that M0 wins the first tie.
module rr_arbiter_2
  import spi_hub_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output master_id_t grant
);

  master_id_t last_grant_q;

  // Tie goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant = M0;
    if (req == 2'b11) begin
      grant = (last_grant_q == M0) ? M1 : M0;
    end else if (req[1]) begin
      grant = M1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= M1;
    end else if (advance) begin
      last_grant_q <= grant;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: two-master arbiter and RAM/Flash region decoder in front of
// the SPI memory controller.
//   clk, reset_n        - clock, synchronous active-low reset
//   m0_* / m1_*         - CPU / loader request ports (req, we, addr, wdata in;
//                         rdata, ready out)
//   mem_req/we/addr/wdata, cs_select - parallel command to the controller
//   mem_rdata, mem_ready - controller response
//   spi_busy            - controller not idle; blocks new grants
//   wp_fault            - Flash write-protect violation pulse
// Optional feature: define FLASH_WP_EN to reject writes that decode to Flash
// (no controller request; ready and wp_fault pulse together). Without it
// wp_fault is always 0.
module spi_mem_arbiter
  import spi_hub_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 16,
  parameter int unsigned        DATA_W     = 16,
  parameter logic [ADDR_W-1:0]  FLASH_BASE = ADDR_W'(FLASH_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              cs_select,
  input  logic              spi_busy,
  output logic              wp_fault
);

  arb_state_t        state_q;
  master_id_t        gnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cs_select_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;
  logic              m0_ready_q;
  logic              m1_ready_q;
  logic              wp_fault_q;

  master_id_t        grant;
  logic              start;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_flash;
  logic [ADDR_W-1:0] dec_addr;
  logic              wp_hit;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({m1_req, m0_req}),
    .advance (start),
    .grant   (grant)
  );

  // A new transaction starts only from IDLE with the controller free.
  assign start = (state_q == IDLE) && (m0_req || m1_req) && !spi_busy;

  // Select the winning master's command and decode its target region.
  always_comb begin
    sel_we    = (grant == M1) ? m1_we    : m0_we;
    sel_addr  = (grant == M1) ? m1_addr  : m0_addr;
    sel_wdata = (grant == M1) ? m1_wdata : m0_wdata;
    sel_flash = (sel_addr >= FLASH_BASE);
    dec_addr  = sel_flash ? ADDR_W'(sel_addr - FLASH_BASE) : sel_addr;
  end

`ifdef FLASH_WP_EN
  assign wp_hit = sel_we && sel_flash;
`else
  assign wp_hit = 1'b0;
`endif

  // Issue FSM; mem_* and cs_select are latched at grant and held until the next grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= M0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cs_select_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      wp_fault_q  <= 1'b0;
    end else begin
      mem_req_q  <= 1'b0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      wp_fault_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            gnt_q       <= grant;
            mem_we_q    <= sel_we;
            mem_addr_q  <= dec_addr;
            mem_wdata_q <= sel_wdata;
            cs_select_q <= sel_flash;
            if (wp_hit) begin
              // Protected Flash write: answer directly, never reach the controller.
              wp_fault_q <= 1'b1;
              m0_ready_q <= (grant == M0);
              m1_ready_q <= (grant == M1);
              state_q    <= RESP;
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (mem_ready) begin
            m0_ready_q <= (gnt_q == M0);
            m1_ready_q <= (gnt_q == M1);
            // Writes leave the master's read-data register untouched.
            if (!mem_we_q) begin
              if (gnt_q == M0) m0_rdata_q <= mem_rdata;
              else             m1_rdata_q <= mem_rdata;
            end
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cs_select = cs_select_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign wp_fault  = wp_fault_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with a scoreboard of expected responses.
// Define FLASH_WP_EN to exercise the write-protect build.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        mem_req, mem_we, cs_select, mem_ready, spi_busy, wp_fault;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  int cnt0  = 0;
  int cnt1  = 0;

  typedef struct {
    int          m;
    logic [15:0] d;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] last_rd[2];

  always #5 clk = ~clk;

  spi_mem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_ready  (m0_ready),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_ready  (m1_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .cs_select (cs_select),
    .spi_busy  (spi_busy),
    .wp_fault  (wp_fault)
  );

  // Ready-pulse counters per master.
  always @(negedge clk) begin
    if (m0_ready === 1'b1) cnt0++;
    if (m1_ready === 1'b1) cnt1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   32'(mem_req),   32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cs"},        32'(cs_select), 32'd0);
    check({tag, "_m0_ready"},  32'(m0_ready),  32'd0);
    check({tag, "_m1_ready"},  32'(m1_ready),  32'd0);
    check({tag, "_m0_rdata"},  32'(m0_rdata),  32'd0);
    check({tag, "_m1_rdata"},  32'(m1_rdata),  32'd0);
    check({tag, "_wp_fault"},  32'(wp_fault),  32'd0);
  endtask

  task automatic set_req(input int m, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd);
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  // Acts as the controller for one transaction; drop: 0 keep req, 1 drop at ready, 2 drop in WAIT.
  task automatic serve(input int m, input logic we, input logic [15:0] exp_addr,
                       input logic exp_cs, input logic [15:0] exp_wd,
                       input logic [15:0] rd, input int lat, input int drop);
    int   n;
    logic stable;
    sb_t  e;
    n = 0;
    while (mem_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mem_req_seen", 32'(mem_req), 32'd1);
    if (mem_req !== 1'b1) return;
    check("mem_addr",  32'(mem_addr),  32'(exp_addr));
    check("cs_select", 32'(cs_select), 32'(exp_cs));
    check("mem_we",    32'(mem_we),    32'(we));
    if (we) check("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
    sb.push_back('{m, (we ? last_rd[m] : rd)});
    if (!we) last_rd[m] = rd;
    if (drop == 2) drop_req(m);
    @(negedge clk);
    check("mem_req_pulse", 32'(mem_req), 32'd0);
    stable = 1'b1;
    for (int i = 0; i < lat; i++) begin
      if (mem_addr !== exp_addr || cs_select !== exp_cs || mem_we !== we ||
          mem_req !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    check("wait_hold_stable", 32'(stable), 32'd1);
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 16'($urandom);
    e = sb.pop_front();
    check("m0_ready", 32'(m0_ready), 32'(e.m == 0));
    check("m1_ready", 32'(m1_ready), 32'(e.m == 1));
    if (e.m == 0) begin
      check("m0_rdata",      32'(m0_rdata), 32'(e.d));
      check("m1_rdata_hold", 32'(m1_rdata), 32'(last_rd[1]));
    end else begin
      check("m1_rdata",      32'(m1_rdata), 32'(e.d));
      check("m0_rdata_hold", 32'(m0_rdata), 32'(last_rd[0]));
    end
    if (drop == 1) drop_req(m);
  endtask

  initial begin
    int   n;
    int   c0;
    logic seen;
    reset_n   = 1'b0;
    m0_req    = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req    = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    spi_busy  = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests held across grants: M0, M1, M0, M1.
    set_req(0, 1'b0, 16'h0100, 16'h0);
    set_req(1, 1'b0, 16'h0200, 16'h0);
    serve(0, 1'b0, 16'h0100, 1'b0, 16'h0, 16'hA0A0, 3, 0);
    serve(1, 1'b0, 16'h0200, 1'b0, 16'h0, 16'hB1B1, 3, 0);
    serve(0, 1'b0, 16'h0100, 1'b0, 16'h0, 16'hA2A2, 3, 1);
    serve(1, 1'b0, 16'h0200, 1'b0, 16'h0, 16'hB3B3, 3, 1);
    repeat (3) @(negedge clk);
    check("tie_cnt0", 32'(cnt0), 32'd2);
    check("tie_cnt1", 32'(cnt1), 32'd2);

    // Long-latency CPU read.
    set_req(0, 1'b0, 16'h0010, 16'h0);
    serve(0, 1'b0, 16'h0010, 1'b0, 16'h0, 16'hBEEF, 80, 1);

    // Region decode boundaries.
    set_req(1, 1'b0, 16'hC123, 16'h0);
    serve(1, 1'b0, 16'h0123, 1'b1, 16'h0, 16'h1111, 2, 1);
    set_req(1, 1'b0, 16'hBFFF, 16'h0);
    serve(1, 1'b0, 16'hBFFF, 1'b0, 16'h0, 16'h2222, 2, 1);
    set_req(0, 1'b0, 16'hC000, 16'h0);
    serve(0, 1'b0, 16'h0000, 1'b1, 16'h0, 16'h3333, 2, 1);
    set_req(0, 1'b0, 16'hFFFF, 16'h0);
    serve(0, 1'b0, 16'h3FFF, 1'b1, 16'h0, 16'h4444, 2, 1);

    // Controller busy blocks the grant.
    spi_busy = 1'b1;
    set_req(0, 1'b0, 16'h0042, 16'h0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req !== 1'b0) seen = 1'b1;
    end
    check("busy_no_req", 32'(seen), 32'd0);
    spi_busy = 1'b0;
    @(negedge clk);
    check("busy_release_req", 32'(mem_req), 32'd1);
    serve(0, 1'b0, 16'h0042, 1'b0, 16'h0, 16'h5A5A, 4, 1);

    // Stray mem_ready in IDLE is ignored.
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("stray_m0_ready", 32'(m0_ready), 32'd0);
    check("stray_m1_ready", 32'(m1_ready), 32'd0);
    @(negedge clk);
    check("stray_mem_req", 32'(mem_req), 32'd0);

    // RAM write is forwarded; read data stays at the last read value.
    set_req(1, 1'b1, 16'h0300, 16'h5555);
    serve(1, 1'b1, 16'h0300, 1'b0, 16'h5555, 16'hDEAD, 3, 1);

    // Flash write.
`ifdef FLASH_WP_EN
    set_req(0, 1'b1, 16'hC000, 16'h1234);
    @(negedge clk);
    check("wp_m0_ready",  32'(m0_ready), 32'd1);
    check("wp_fault",     32'(wp_fault), 32'd1);
    check("wp_mem_req",   32'(mem_req),  32'd0);
    check("wp_m0_rdata",  32'(m0_rdata), 32'(last_rd[0]));
    drop_req(0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || wp_fault !== 1'b0 || m0_ready !== 1'b0) seen = 1'b1;
    end
    check("wp_quiet_after", 32'(seen), 32'd0);
`else
    set_req(0, 1'b1, 16'hC000, 16'h1234);
    serve(0, 1'b1, 16'h0000, 1'b1, 16'h1234, 16'hFACE, 3, 1);
    check("wp_fault_tied", 32'(wp_fault), 32'd0);
`endif

    // Dropping req during WAIT still completes.
    set_req(1, 1'b0, 16'h0404, 16'h0);
    serve(1, 1'b0, 16'h0404, 1'b0, 16'h0, 16'h0B0B, 5, 2);

    // Reset in WAIT abandons the transaction.
    @(negedge clk);
    set_req(0, 1'b0, 16'h0777, 16'h0);
    n = 0;
    while (mem_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_mem_req", 32'(mem_req), 32'd1);
    repeat (3) @(negedge clk);
    c0 = cnt0;
    reset_n = 1'b0;
    drop_req(0);
    @(negedge clk);
    check_all_zero("midreset");
    reset_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (4) @(negedge clk);
    check("abort_no_ready", 32'(cnt0), 32'(c0));
    set_req(0, 1'b0, 16'h0888, 16'h0);
    serve(0, 1'b0, 16'h0888, 1'b0, 16'h0, 16'h7777, 3, 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
